// File: rtl/fp_pkg.sv
// fp_pkg: types and helpers shared by the fixed-priority queue selector and
// its downstream dispatcher.
package fp_pkg;

    // Dispatcher FSM: wait for a grant, fetch one word, present it downstream.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } fp_dispatch_state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int fp_id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fp_served_counters.sv
// fp_served_counters: one wrapping packet counter per queue, bumped by a
// single increment strobe addressed by queue index.
module fp_served_counters
    import fp_pkg::*;
#(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int COUNTER_WIDTH    = 16,
    localparam int ID_W            = fp_id_width(NUMBER_OF_QUEUES)
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      inc,
    input  logic [ID_W-1:0]                           inc_id,
    output logic [NUMBER_OF_QUEUES*COUNTER_WIDTH-1:0] count
);

    logic [COUNTER_WIDTH-1:0] cnt_r [NUMBER_OF_QUEUES];

    // Counter bank: only the addressed counter moves, wrapping naturally.
    always_ff @(posedge clock) begin
        for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
            if (reset) begin
                cnt_r[q] <= '0;
            end else if (inc && (inc_id == ID_W'(q))) begin
                cnt_r[q] <= cnt_r[q] + COUNTER_WIDTH'(1);
            end else begin
                cnt_r[q] <= cnt_r[q];
            end
        end
    end

    for (genvar q = 0; q < NUMBER_OF_QUEUES; q++) begin : g_flatten
        assign count[q*COUNTER_WIDTH +: COUNTER_WIDTH] = cnt_r[q];
    end

endmodule

// File: rtl/fp_dispatcher.sv
// fp_dispatcher: locks onto the queue chosen by the fixed-priority selector and
// drains one PACKET_BEATS-word packet from its FWFT FIFO onto a valid/ready
// master port, one word at a time. Arbitration happens only between packets.
// Optional per-queue served-packet counters: define FP_DISPATCHER_STATS_EN.
module fp_dispatcher
    import fp_pkg::*;
#(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int DATA_WIDTH       = 64,
    parameter int PACKET_BEATS     = 4,
    parameter int COUNTER_WIDTH    = 16,
    localparam int ID_W            = fp_id_width(NUMBER_OF_QUEUES)
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   valid,
    input  logic [ID_W-1:0]                        selection,
    input  logic [NUMBER_OF_QUEUES-1:0]            empty,
    input  logic [NUMBER_OF_QUEUES*DATA_WIDTH-1:0] queue_data,
    output logic [NUMBER_OF_QUEUES-1:0]            pop,
    output logic                                   m_valid,
    input  logic                                   m_ready,
    output logic [DATA_WIDTH-1:0]                  m_data,
    output logic [ID_W-1:0]                        m_queue_id,
    output logic                                   m_last,
    output logic                                   busy
`ifdef FP_DISPATCHER_STATS_EN
    ,
    output logic [NUMBER_OF_QUEUES*COUNTER_WIDTH-1:0] served_count
`endif
);

    localparam int BEAT_W = fp_id_width(PACKET_BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PACKET_BEATS - 1);

    if ((PACKET_BEATS < 1) || (NUMBER_OF_QUEUES < 1) || (COUNTER_WIDTH < 1)) begin : g_bad_params
        $error("fp_dispatcher: PACKET_BEATS, NUMBER_OF_QUEUES and COUNTER_WIDTH must be >= 1");
    end

    fp_dispatch_state_t     state_r, state_next_s;
    logic [ID_W-1:0]        grant_id_r, grant_id_next_s;
    logic [BEAT_W-1:0]      beat_cnt_r, beat_cnt_next_s;
    logic                   m_valid_r, m_valid_next_s;
    logic                   m_last_r, m_last_next_s;
    logic [DATA_WIDTH-1:0]  m_data_r, m_data_next_s;
    logic [NUMBER_OF_QUEUES-1:0] pop_s;
    logic                   sel_in_range_s;
    logic                   req_ok_s;
    logic [DATA_WIDTH-1:0]  queue_word_s [NUMBER_OF_QUEUES];

    for (genvar q = 0; q < NUMBER_OF_QUEUES; q++) begin : g_unpack
        assign queue_word_s[q] = queue_data[q*DATA_WIDTH +: DATA_WIDTH];
    end

    // A selection id can only be out of range when the queue count is not a power of two.
    if (NUMBER_OF_QUEUES == (1 << ID_W)) begin : g_full_range
        assign sel_in_range_s = 1'b1;
    end else begin : g_partial_range
        assign sel_in_range_s = (selection < ID_W'(NUMBER_OF_QUEUES));
    end

    assign req_ok_s = valid && sel_in_range_s && !empty[selection];

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state, pop strobe and next values of the packet/output registers.
    always_comb begin
        state_next_s    = state_r;
        grant_id_next_s = grant_id_r;
        beat_cnt_next_s = beat_cnt_r;
        m_valid_next_s  = m_valid_r;
        m_last_next_s   = m_last_r;
        m_data_next_s   = m_data_r;
        pop_s           = '0;
        case (state_r)
            IDLE: begin
                if (req_ok_s) begin
                    state_next_s    = LOAD;
                    grant_id_next_s = selection;
                    beat_cnt_next_s = '0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD: begin
                // Never switch queues mid-packet: a dry queue just stalls here.
                if (!empty[grant_id_r]) begin
                    pop_s[grant_id_r] = 1'b1;
                    m_data_next_s     = queue_word_s[grant_id_r];
                    m_valid_next_s    = 1'b1;
                    m_last_next_s     = (beat_cnt_r == LAST_BEAT);
                    state_next_s      = SEND;
                end else begin
                    state_next_s = LOAD;
                end
            end
            SEND: begin
                if (m_ready) begin
                    m_valid_next_s = 1'b0;
                    if (m_last_r) begin
                        state_next_s = IDLE;
                    end else begin
                        beat_cnt_next_s = beat_cnt_r + BEAT_W'(1);
                        state_next_s    = LOAD;
                    end
                end else begin
                    state_next_s = SEND;
                end
            end
            default: begin
                state_next_s   = IDLE;
                m_valid_next_s = 1'b0;
            end
        endcase
    end

    // Grant, beat counter and master-port registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            grant_id_r <= '0;
            beat_cnt_r <= '0;
            m_valid_r  <= 1'b0;
            m_last_r   <= 1'b0;
            m_data_r   <= '0;
        end else begin
            grant_id_r <= grant_id_next_s;
            beat_cnt_r <= beat_cnt_next_s;
            m_valid_r  <= m_valid_next_s;
            m_last_r   <= m_last_next_s;
            m_data_r   <= m_data_next_s;
        end
    end

    assign pop        = pop_s;
    assign m_valid    = m_valid_r;
    assign m_last     = m_last_r;
    assign m_data     = m_data_r;
    assign m_queue_id = grant_id_r;
    assign busy       = (state_r != IDLE);

`ifdef FP_DISPATCHER_STATS_EN
    logic pkt_done_s;

    // A packet completes when its last beat is accepted.
    assign pkt_done_s = (state_r == SEND) && m_ready && m_last_r;

    fp_served_counters #(
        .NUMBER_OF_QUEUES (NUMBER_OF_QUEUES),
        .COUNTER_WIDTH    (COUNTER_WIDTH)
    ) u_served_counters (
        .clock  (clock),
        .reset  (reset),
        .inc    (pkt_done_s),
        .inc_id (grant_id_r),
        .count  (served_count)
    );
`endif

endmodule

// File: doc/fp_dispatcher.md
# fp_dispatcher

Downstream stage of the fixed-priority queue selector. Takes the selector's `valid`/`selection` result, locks onto the chosen queue, and drains one packet of `PACKET_BEATS` words from that queue's first-word-fall-through FIFO. It forwards the packet beat by beat on a valid/ready master port toward the memory interface. Arbitration is non-preemptive: a new selection is sampled only between packets.

## Interface
Parameters:
- `NUMBER_OF_QUEUES`, 4, number of input queues; must match the selector.
- `DATA_WIDTH`, 64, width of one queue word / output beat.
- `PACKET_BEATS`, 4, words per packet; must be ≥ 1.
- `COUNTER_WIDTH`, 16, width of each served-packet counter (stats build only).

Ports (`ID_W = max(1, $clog2(NUMBER_OF_QUEUES))`):
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `valid`  in  1  selector reports at least one non-empty queue.
- `selection`  in  ID_W  selector's winning queue id.
- `empty`  in  NUMBER_OF_QUEUES  per-queue empty flags, the same vector the selector sees.
- `queue_data`  in  NUMBER_OF_QUEUES×DATA_WIDTH  front word of each FWFT queue.
- `pop`  out  NUMBER_OF_QUEUES  one-hot dequeue strobe; combinational.
- `m_valid`  out  1  output beat valid; registered.
- `m_ready`  in  1  downstream accepts the beat.
- `m_data`  out  DATA_WIDTH  output beat; registered.
- `m_queue_id`  out  ID_W  source queue of the current packet.
- `m_last`  out  1  final beat of the packet.
- `busy`  out  1  a packet is in progress (state ≠ IDLE).
- `served_count`  out  NUMBER_OF_QUEUES×COUNTER_WIDTH  completed packets per queue (stats build only).

## Operation
- FSM states: `IDLE`, `LOAD`, `SEND`.
- **IDLE:**
  - Leaves IDLE only when `valid`=1, `selection` < NUMBER_OF_QUEUES, and `empty[selection]`=0.
  - On leaving: latch `grant_id`←`selection`, `beat_cnt`←0, go to LOAD.
  - An out-of-range `selection` counts as no request; the FSM stays in IDLE.
- **LOAD:**
  - If `empty[grant_id]`=0: assert `pop[grant_id]`=1 in this cycle. Register `m_data`←`queue_data[grant_id]`, `m_valid`←1, `m_last`←(`beat_cnt`==PACKET_BEATS-1). Go to SEND.
  - If `empty[grant_id]`=1 (queue ran dry mid-packet): `pop`=0 and the FSM stays in LOAD until data arrives. It never switches queue mid-packet.
- **SEND:**
  - `m_valid`=1. `m_data`, `m_last` and `m_queue_id` are held stable until `m_ready`=1.
  - On `m_ready`=1: `m_valid`←0.
  - If `m_last`=1, go to IDLE. Otherwise `beat_cnt`←`beat_cnt`+1 and go to LOAD.
- `pop` is never asserted outside LOAD and never asserted when the queue is empty. At most one bit is set.
- `valid`/`selection` are ignored while `busy`=1.
- `m_queue_id` = `grant_id`.
- `beat_cnt` width is `max(1,$clog2(PACKET_BEATS))`. With PACKET_BEATS=1, `m_last` is always 1.

## Timing
- Reset values: state IDLE, `m_valid`=0, `m_last`=0, `m_data`=0, `m_queue_id`=0, `grant_id`=0, `beat_cnt`=0, `pop`=0, `busy`=0, every `served_count`=0.
- Latency: with `valid` sampled in IDLE at cycle t, `pop` is asserted in t+1 and `m_valid` rises in t+2.
- Throughput: with `m_ready` held at 1, one beat every 2 cycles. A packet occupies 2·PACKET_BEATS+1 cycles including the IDLE sample cycle.
- Back-pressure: SEND holds indefinitely while `m_ready`=0, and no further `pop` is issued.
- Reset mid-packet: the FSM returns to IDLE on the next edge and all outputs take their reset values. Words already popped are discarded; the queues must be reset in the same cycle.

## Configuration
- Macro: `FP_DISPATCHER_STATS_EN`.
- Defined:
  - Port `served_count` exists.
  - `served_count[grant_id]` increments by 1 on each SEND→IDLE transition.
  - Counters wrap modulo 2^COUNTER_WIDTH.
- Undefined: the port and all counters are absent; the remaining behaviour is identical.

## Structure
- The shared package `fp_pkg` holds:
  - typedef `fp_dispatch_state_t` (IDLE, LOAD, SEND);
  - the `ID_W` derivation as a constant function, also used by the selector.
- Sub-module `fp_served_counters`: a bank of NUMBER_OF_QUEUES counters with an increment strobe and index. It is instantiated only under `FP_DISPATCHER_STATS_EN`.

## Test plan
- **Reset defaults:** reset held 3 cycles with `valid`=1 → all outputs 0; after release, `m_valid` first rises 2 cycles after the first sampled `valid`.
- **Single packet:** N=4, PACKET_BEATS=4, `selection`=2, queue 2 holds words 0xA0..0xA3, `m_ready`=1 → four beats 0xA0..0xA3 with `m_queue_id`=2. `m_last` is set only on 0xA3, and `pop[2]` pulses exactly 4 times.
- **Back-pressure:** `m_ready`=0 for 5 cycles on beat 1 → `m_data` is held stable and no `pop` occurs. On release the remaining beats continue in order.
- **Non-preemption:** during a queue-1 packet, `selection` changes to 3 → the queue-1 packet completes. The next packet is from queue 3, and there is exactly one IDLE cycle between the packets.
- **Mid-packet underflow:** queue 0 becomes empty after beat 2 for 4 cycles → FSM stays in LOAD with `pop`=0, then resumes with beat 3 from queue 0.
- **Stats and reset:** with `FP_DISPATCHER_STATS_EN` and COUNTER_WIDTH=2, five packets from queue 1 → `served_count[1]`=1 after wrap. Reset asserted mid-packet → state IDLE, counters 0, `m_valid`=0 on the next edge.
